// File: rtl/mem_bus_if.sv
// External memory bus interface: converts single-cycle core requests into a
// multiplexed address/data pad cycle (ALE, nME, nOE, nWE) with programmable
// wait states, nWait stretching and a stretch timeout.
//
// Handshake: Req is sampled only while the interface is IDLE (Busy=0). An
// accepted request is answered by exactly one Done pulse. A Req seen while
// Busy is dropped, not queued. Err is valid only together with Done.
module mem_bus_if #(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Write,
  input  logic [15:0] Addr,
  input  logic [15:0] WData,
  output logic [15:0] RData,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [15:0] AdOut,
  output logic        AdOe,
  input  logic [15:0] AdIn,
  output logic        ALE,
  output logic        nME,
  output logic        nOE,
  output logic        nWE,
  input  logic        nWait,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [2:0] WS_INIT = 3'(WAIT_STATES);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        write_q;
  logic [15:0] rdata_q;
  logic [2:0]  wcnt_q;
  logic [7:0]  tcnt_q;
  logic        err_q;

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; ACCESS leaves on nWait release or on the last stretch cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Req) state_d = ADDR;
      ADDR:    state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (wcnt_q == 3'd0) begin
          if (nWait)                 state_d = FINISH;
          else if (tcnt_q == TO_LAST) state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, wait/timeout counters, read capture and error flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          err_q <= 1'b0;
          if (Req) begin
            addr_q  <= Addr;
            wdata_q <= WData;
            write_q <= Write;
          end
        end
        SETUP: begin
          wcnt_q <= WS_INIT;
          tcnt_q <= '0;
        end
        ACCESS: begin
          if (wcnt_q != 3'd0) begin
            wcnt_q <= wcnt_q - 3'd1;
          end else if (nWait) begin
            if (!write_q) rdata_q <= AdIn;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
            if (tcnt_q == TO_LAST) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pad and status outputs, decoded purely from registered state.
  always_comb begin
    Busy  = (state_q != IDLE);
    Done  = (state_q == FINISH);
    Err   = (state_q == FINISH) && err_q;
    ALE   = (state_q == ADDR);
    nME   = !((state_q == ADDR) || (state_q == SETUP) || (state_q == ACCESS));
    nOE   = !((state_q == ACCESS) && !write_q);
    nWE   = !((state_q == ACCESS) && write_q);
    AdOe  = (state_q == ADDR) || (state_q == SETUP) ||
            ((state_q == ACCESS) && write_q);
    AdOut = '0;
    if ((state_q == ADDR) || (state_q == SETUP)) AdOut = addr_q;
    else if ((state_q == ACCESS) && write_q)     AdOut = wdata_q;
  end

  assign RData     = rdata_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if (WAIT_STATES=1, TIMEOUT=15): a table of bus
// cycles with hand-computed timing/data, plus sequences for Req-while-busy and
// reset in the middle of a write.
module tb_mem_bus_if;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Req = 1'b0;
  logic        Write = 1'b0;
  logic [15:0] Addr = '0;
  logic [15:0] WData = '0;
  logic [15:0] RData;
  logic        Busy, Done, Err;
  logic [15:0] AdOut;
  logic        AdOe;
  logic [15:0] AdIn = '0;
  logic        ALE, nME, nOE, nWE;
  logic        nWait = 1'b1;
  logic [2:0]  state_dbg;

  int n_vec  = 0;
  int n_fail = 0;

  mem_bus_if #(.WAIT_STATES(1), .TIMEOUT(15)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .Write(Write), .Addr(Addr),
    .WData(WData), .RData(RData), .Busy(Busy), .Done(Done), .Err(Err),
    .AdOut(AdOut), .AdOe(AdOe), .AdIn(AdIn), .ALE(ALE), .nME(nME),
    .nOE(nOE), .nWE(nWE), .nWait(nWait), .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 Clock = ~Clock;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] adin;
    int          nlow;     // nWait low cycles after wait expiry, 99 = forever
    int          done_cyc; // cycle of Done counted from the acceptance edge
    logic [15:0] rdata;
    logic        err;
    int          oe_cnt;
    int          we_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver + monitor for one bus cycle; pulse_req re-strobes Req in ADDR and FINISH.
  task automatic run(input vec_t v, input bit pulse_req);
    int c, ale_cnt, ale_bad, oe_cnt, we_cnt, bus_bad, nme_cnt, done_cyc, done_cnt, busy_low;
    ale_cnt = 0; ale_bad = 0; oe_cnt = 0; we_cnt = 0; bus_bad = 0;
    nme_cnt = 0; done_cyc = -1; done_cnt = 0; busy_low = 0;
    @(negedge Clock);
    Req = 1'b1; Write = v.wr; Addr = v.addr; WData = v.wdata; AdIn = v.adin;
    for (c = 1; c <= 40; c++) begin
      @(negedge Clock);
      Req = pulse_req && (c == 1);
      Addr = ~v.addr; WData = ~v.wdata;
      nWait = !((c >= 4) && (c < 4 + v.nlow));
      if (ALE) begin
        ale_cnt++;
        if (AdOut !== v.addr || !AdOe || nME) ale_bad++;
      end
      if (!nOE) oe_cnt++;
      if (!nWE) begin
        we_cnt++;
        if (AdOut !== v.wdata || !AdOe) bus_bad++;
      end
      if (!nME) nme_cnt++;
      if (!Busy) busy_low++;
      check("inv_oe_we", int'(!nOE && !nWE), 0);
      check("inv_ale", int'(ALE && (!nOE || !nWE)), 0);
      if (Done) begin
        done_cnt++;
        done_cyc = c;
        check("rdata", int'(RData), int'(v.rdata));
        check("err", int'(Err), int'(v.err));
        Req = pulse_req;
        break;
      end
    end
    if (done_cyc < 0) $display("FAIL done_timeout: got none expected cycle %0d", v.done_cyc);
    check("done_cyc", done_cyc, v.done_cyc);
    check("ale_cnt", ale_cnt, 1);
    check("ale_addr", ale_bad, 0);
    check("oe_cnt", oe_cnt, v.oe_cnt);
    check("we_cnt", we_cnt, v.we_cnt);
    check("we_data", bus_bad, 0);
    check("nme_cnt", nme_cnt, v.done_cyc - 1);
    check("busy_in_cycle", busy_low, 0);
    nWait = 1'b1;
    // Three idle cycles: no restart from a Req dropped while busy, Err cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      Req = 1'b0;
      check("idle_busy", int'(Busy), 0);
      check("idle_done", int'(Done), 0);
      check("idle_err", int'(Err), 0);
      check("idle_rdata", int'(RData), int'(v.rdata));
    end
  endtask

  initial begin
    vec_t t;
    //            wr    addr      wdata     adin      nlow done rdata     err  oe  we
    vecs[0] = '{1'b0, 16'h1234, 16'h0000, 16'hBEEF, 0,  5,  16'hBEEF, 1'b0, 2,  0};
    vecs[1] = '{1'b1, 16'h00F0, 16'hA5A5, 16'h3C3C, 0,  5,  16'hBEEF, 1'b0, 0,  2};
    vecs[2] = '{1'b0, 16'h4000, 16'h0000, 16'h1357, 3,  8,  16'h1357, 1'b0, 5,  0};
    vecs[3] = '{1'b0, 16'h5555, 16'h0000, 16'hDEAD, 99, 19, 16'h1357, 1'b1, 16, 0};
    vecs[4] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0001, 0,  5,  16'h0001, 1'b0, 2,  0};
    vecs[5] = '{1'b1, 16'h0000, 16'hFFFF, 16'h7777, 2,  7,  16'h0001, 1'b0, 0,  4};

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Done), 0);
    check("rst_err", int'(Err), 0);
    check("rst_rdata", int'(RData), 0);
    check("rst_adout", int'(AdOut), 0);
    check("rst_adoe", int'(AdOe), 0);
    check("rst_ale", int'(ALE), 0);
    check("rst_nme", int'(nME), 1);
    check("rst_noe", int'(nOE), 1);
    check("rst_nwe", int'(nWE), 1);

    for (int i = 0; i < 6; i++) run(vecs[i], 1'b0);

    // Req strobed in ADDR and FINISH: one Done, no follow-on cycle.
    t = '{1'b0, 16'h2468, 16'h0000, 16'hCAFE, 0, 5, 16'hCAFE, 1'b0, 2, 0};
    run(t, 1'b1);
    t = '{1'b1, 16'h1111, 16'h2222, 16'h0000, 0, 5, 16'hCAFE, 1'b0, 0, 2};
    run(t, 1'b0);

    // Reset during ACCESS of a write.
    @(negedge Clock);
    Req = 1'b1; Write = 1'b1; Addr = 16'h0ABC; WData = 16'h5A5A;
    @(negedge Clock); Req = 1'b0;      // ADDR
    @(negedge Clock);                  // SETUP
    @(negedge Clock);                  // ACCESS
    check("pre_rst_nwe", int'(nWE), 0);
    Reset = 1'b1;
    @(negedge Clock);
    check("mid_rst_nwe", int'(nWE), 1);
    check("mid_rst_nme", int'(nME), 1);
    check("mid_rst_adoe", int'(AdOe), 0);
    check("mid_rst_busy", int'(Busy), 0);
    check("mid_rst_done", int'(Done), 0);
    check("mid_rst_rdata", int'(RData), 0);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      check("post_rst_done", int'(Done), 0);
      check("post_rst_busy", int'(Busy), 0);
    end
    t = '{1'b0, 16'h8001, 16'h0000, 16'h6543, 1, 6, 16'h6543, 1'b0, 3, 0};
    run(t, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
